// File: rtl/dmem_port_arbiter_if.sv
// Data-memory port bundle: CPU requester, loader requester and the shared memory port.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface dmem_port_arbiter_if #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [BUS_WIDTH-1:0]  cpu_wdata;
   logic                  cpu_gnt;
   logic                  cpu_stall;
   logic                  cpu_rvalid;
   logic [BUS_WIDTH-1:0]  cpu_rdata;

   logic                  ldr_req;
   logic                  ldr_we;
   logic [ADDR_WIDTH-1:0] ldr_addr;
   logic [BUS_WIDTH-1:0]  ldr_wdata;
   logic                  ldr_last;
   logic                  ldr_gnt;
   logic                  ldr_rvalid;
   logic [BUS_WIDTH-1:0]  ldr_rdata;

   logic                  mem_we;
   logic                  mem_re;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [BUS_WIDTH-1:0]  mem_wdata;
   logic [BUS_WIDTH-1:0]  mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_last,
      output ldr_gnt, ldr_rvalid, ldr_rdata,
      output mem_we, mem_re, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_last,
      input  ldr_gnt, ldr_rvalid, ldr_rdata,
      input  mem_we, mem_re, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and the NN weight loader.
// The CPU has priority. A wait counter forces loader progress, and loader bursts lock the port.
module dmem_port_arbiter #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_WAIT   = 8,
   parameter int MAX_BURST  = 16
) (
   input logic                CLK,
   input logic                RSTn,
   dmem_port_arbiter_if.slave bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(MAX_BURST);
   localparam logic [BEAT_W-1:0] BEAT_ONE   = BEAT_W'(1);

   typedef enum logic [0:0] {CPU_PRI = 1'b0, LDR_BURST = 1'b1} arbState_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_LDR = 2'd2} owner_t;

   arbState_t         state_r;
   owner_t            owner_r;
   logic              active_r;
   logic [WAIT_W-1:0] waitCnt_r;
   logic [BEAT_W-1:0] beatCnt_r;
   logic [BEAT_W-1:0] beatNext_s;
   logic              cpuGnt_s;
   logic              ldrGnt_s;

   assign beatNext_s = beatCnt_r + BEAT_ONE;

   // Grant decision for the current request cycle
   always_comb begin
      cpuGnt_s = 1'b0;
      ldrGnt_s = 1'b0;
      if (active_r) begin
         case (state_r)
            CPU_PRI: begin
               // A starved loader overrides the CPU once the wait budget is spent
               if (bus.ldr_req && (waitCnt_r == WAIT_LIMIT)) begin
                  ldrGnt_s = 1'b1;
               end else if (bus.cpu_req) begin
                  cpuGnt_s = 1'b1;
               end else if (bus.ldr_req) begin
                  ldrGnt_s = 1'b1;
               end else begin
                  cpuGnt_s = 1'b0;
                  ldrGnt_s = 1'b0;
               end
            end
            LDR_BURST: begin
               ldrGnt_s = bus.ldr_req;
            end
            default: begin
               cpuGnt_s = 1'b0;
               ldrGnt_s = 1'b0;
            end
         endcase
      end else begin
         cpuGnt_s = 1'b0;
         ldrGnt_s = 1'b0;
      end
   end

   // Memory port mux driven by the granted requester
   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = {ADDR_WIDTH{1'b0}};
      bus.mem_wdata = {BUS_WIDTH{1'b0}};
      if (cpuGnt_s) begin
         bus.mem_we    = bus.cpu_we;
         bus.mem_re    = !bus.cpu_we;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end else if (ldrGnt_s) begin
         bus.mem_we    = bus.ldr_we;
         bus.mem_re    = !bus.ldr_we;
         bus.mem_addr  = bus.ldr_addr;
         bus.mem_wdata = bus.ldr_wdata;
      end else begin
         bus.mem_we    = 1'b0;
         bus.mem_re    = 1'b0;
         bus.mem_addr  = {ADDR_WIDTH{1'b0}};
         bus.mem_wdata = {BUS_WIDTH{1'b0}};
      end
   end

   assign bus.cpu_gnt    = cpuGnt_s;
   assign bus.ldr_gnt    = ldrGnt_s;
   assign bus.cpu_stall  = bus.cpu_req && !cpuGnt_s;
   assign bus.cpu_rvalid = (owner_r == OWN_CPU);
   assign bus.ldr_rvalid = (owner_r == OWN_LDR);
   assign bus.cpu_rdata  = (owner_r == OWN_CPU) ? bus.mem_rdata : {BUS_WIDTH{1'b0}};
   assign bus.ldr_rdata  = (owner_r == OWN_LDR) ? bus.mem_rdata : {BUS_WIDTH{1'b0}};

   // Arbiter state: start-up gate, wait/beat counters, burst lock and read-return owner
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         active_r  <= 1'b0;
         state_r   <= CPU_PRI;
         owner_r   <= OWN_NONE;
         waitCnt_r <= {WAIT_W{1'b0}};
         beatCnt_r <= {BEAT_W{1'b0}};
      end else begin
         active_r <= 1'b1;

         if (bus.ldr_req && !ldrGnt_s) begin
            if (waitCnt_r != WAIT_LIMIT) begin
               waitCnt_r <= waitCnt_r + WAIT_ONE;
            end else begin
               waitCnt_r <= waitCnt_r;
            end
         end else begin
            waitCnt_r <= {WAIT_W{1'b0}};
         end

         if (cpuGnt_s && !bus.cpu_we) begin
            owner_r <= OWN_CPU;
         end else if (ldrGnt_s && !bus.ldr_we) begin
            owner_r <= OWN_LDR;
         end else begin
            owner_r <= OWN_NONE;
         end

         case (state_r)
            CPU_PRI: begin
               // The first beat is counted here, so a one-beat cap never enters the lock
               if (ldrGnt_s && !bus.ldr_last && (BEAT_LIMIT != BEAT_ONE)) begin
                  state_r   <= LDR_BURST;
                  beatCnt_r <= BEAT_ONE;
               end else begin
                  state_r   <= CPU_PRI;
                  beatCnt_r <= {BEAT_W{1'b0}};
               end
            end
            LDR_BURST: begin
               if (!ldrGnt_s || bus.ldr_last || (beatNext_s == BEAT_LIMIT)) begin
                  state_r   <= CPU_PRI;
                  beatCnt_r <= {BEAT_W{1'b0}};
               end else begin
                  state_r   <= LDR_BURST;
                  beatCnt_r <= beatNext_s;
               end
            end
            default: begin
               state_r   <= CPU_PRI;
               beatCnt_r <= {BEAT_W{1'b0}};
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small synchronous memory model behind the port.
module tb_dmem_port_arbiter;
   logic CLK;
   logic RSTn;
   int   checkCnt;
   int   failCnt;
   logic [31:0] memArr [0:1023];

   dmem_port_arbiter_if #(.BUS_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   dmem_port_arbiter #(
      .BUS_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(8), .MAX_BURST(16)
   ) dut (
      .CLK (CLK),
      .RSTn(RSTn),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory model: write commits on the edge, read data appears one cycle after mem_re
   always @(posedge CLK) begin
      if (bus.mem_we) memArr[bus.mem_addr[9:0]] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= memArr[bus.mem_addr[9:0]];
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic setCpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = data;
   endtask

   task automatic setLdr(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic last);
      bus.ldr_req   = req;
      bus.ldr_we    = we;
      bus.ldr_addr  = addr;
      bus.ldr_wdata = data;
      bus.ldr_last  = last;
   endtask

   initial begin
      logic expLdr;
      checkCnt = 0;
      failCnt  = 0;
      bus.mem_rdata = 32'h0;
      for (int i = 0; i < 1024; i++) memArr[i] = 32'h0;

      // Reset with both requesters active
      RSTn = 1'b0;
      setCpu(1'b1, 1'b0, 32'h0, 32'h0);
      setLdr(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge CLK);
      checkVal("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      checkVal("rst_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      checkVal("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkVal("rst_mem_re", 32'(bus.mem_re), 32'd0);
      checkVal("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      checkVal("rst_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd0);
      nextCycle();
      RSTn = 1'b1;
      @(negedge CLK);
      checkVal("rel_c1_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      checkVal("rel_c1_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      nextCycle();
      @(negedge CLK);
      checkVal("rel_c2_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      checkVal("rel_c2_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      nextCycle();
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      setLdr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      nextCycle();

      // CPU write then read-back
      setCpu(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      @(negedge CLK);
      checkVal("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      checkVal("wr_mem_we", 32'(bus.mem_we), 32'd1);
      checkVal("wr_mem_addr", bus.mem_addr, 32'h10);
      checkVal("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
      nextCycle();
      setCpu(1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge CLK);
      checkVal("rd_mem_re", 32'(bus.mem_re), 32'd1);
      checkVal("rd_mem_we", 32'(bus.mem_we), 32'd0);
      nextCycle();
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      checkVal("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
      checkVal("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      checkVal("rd_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd0);
      nextCycle();
      @(negedge CLK);
      checkVal("rd_after_rvalid", 32'(bus.cpu_rvalid), 32'd0);
      checkVal("rd_after_rdata", bus.cpu_rdata, 32'h0);
      nextCycle();

      // Starvation: eight CPU grants, forced loader grant, then CPU again
      setCpu(1'b1, 1'b0, 32'h20, 32'h0);
      setLdr(1'b1, 1'b1, 32'h200, 32'h55, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         checkVal($sformatf("starve_c%0d_cpu_gnt", c), 32'(bus.cpu_gnt), (c == 9) ? 32'd0 : 32'd1);
         checkVal($sformatf("starve_c%0d_ldr_gnt", c), 32'(bus.ldr_gnt), (c == 9) ? 32'd1 : 32'd0);
         if (c == 9) begin
            checkVal("starve_stall", 32'(bus.cpu_stall), 32'd1);
            checkVal("starve_mem_addr", bus.mem_addr, 32'h200);
         end
         nextCycle();
      end
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      setLdr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      nextCycle();

      // Four-beat locked burst, CPU joins on beat 2
      for (int b = 0; b < 4; b++) begin
         setLdr(1'b1, 1'b1, 32'h100 + 32'(b), 32'hA0 + 32'(b), b == 3);
         setCpu(b >= 1, 1'b0, 32'h10, 32'h0);
         @(negedge CLK);
         checkVal($sformatf("burst_b%0d_ldr_gnt", b + 1), 32'(bus.ldr_gnt), 32'd1);
         checkVal($sformatf("burst_b%0d_cpu_gnt", b + 1), 32'(bus.cpu_gnt), 32'd0);
         checkVal($sformatf("burst_b%0d_stall", b + 1), 32'(bus.cpu_stall), (b >= 1) ? 32'd1 : 32'd0);
         checkVal($sformatf("burst_b%0d_addr", b + 1), bus.mem_addr, 32'h100 + 32'(b));
         nextCycle();
      end
      setLdr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      setCpu(1'b1, 1'b0, 32'h102, 32'h0);
      @(negedge CLK);
      checkVal("burst_end_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      checkVal("burst_end_stall", 32'(bus.cpu_stall), 32'd0);
      nextCycle();
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge CLK);
      checkVal("burst_rd_rdata", bus.cpu_rdata, 32'hA2);
      nextCycle();

      // Burst cap: 8 CPU, 16 LDR, 8 CPU, then a forced LDR grant
      setCpu(1'b1, 1'b0, 32'h10, 32'h0);
      setLdr(1'b1, 1'b1, 32'h300, 32'h33, 1'b0);
      for (int c = 1; c <= 33; c++) begin
         expLdr = ((c >= 9) && (c <= 24)) || (c == 33);
         @(negedge CLK);
         checkVal($sformatf("cap_c%0d_ldr_gnt", c), 32'(bus.ldr_gnt), 32'(expLdr));
         checkVal($sformatf("cap_c%0d_cpu_gnt", c), 32'(bus.cpu_gnt), 32'(!expLdr));
         nextCycle();
      end
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      setLdr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge CLK);
      checkVal("cap_abort_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      nextCycle();

      // Reset pulse during beat 3 of a loader read burst
      setLdr(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
      @(negedge CLK);
      checkVal("abort_b1_ldr_gnt", 32'(bus.ldr_gnt), 32'd1);
      nextCycle();
      setLdr(1'b1, 1'b0, 32'h101, 32'h0, 1'b0);
      @(negedge CLK);
      checkVal("abort_b2_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd1);
      checkVal("abort_b2_ldr_rdata", bus.ldr_rdata, 32'hA0);
      nextCycle();
      setLdr(1'b1, 1'b0, 32'h102, 32'h0, 1'b0);
      checkVal("abort_b3_ldr_gnt", 32'(bus.ldr_gnt), 32'd1);
      checkVal("abort_b3_ldr_rdata", bus.ldr_rdata, 32'hA1);
      #1;
      RSTn = 1'b0;
      #1;
      checkVal("abort_rst_ldr_rvalid", 32'(bus.ldr_rvalid), 32'd0);
      checkVal("abort_rst_ldr_rdata", bus.ldr_rdata, 32'h0);
      checkVal("abort_rst_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      checkVal("abort_rst_mem_we", 32'(bus.mem_we), 32'd0);
      setCpu(1'b1, 1'b0, 32'h10, 32'h0);
      setLdr(1'b1, 1'b1, 32'h104, 32'h77, 1'b0);
      nextCycle();
      RSTn = 1'b1;
      @(negedge CLK);
      checkVal("abort_c1_mem_we", 32'(bus.mem_we), 32'd0);
      checkVal("abort_c1_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      checkVal("abort_c1_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
      nextCycle();
      @(negedge CLK);
      checkVal("abort_c2_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
      checkVal("abort_c2_ldr_gnt", 32'(bus.ldr_gnt), 32'd0);
      checkVal("abort_c2_mem_we", 32'(bus.mem_we), 32'd0);
      nextCycle();
      setCpu(1'b0, 1'b0, 32'h0, 32'h0);
      setLdr(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge CLK);
      checkVal("abort_rd_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
      $finish;
   end
endmodule
